// File: rtl/gravsim_pkg.sv
// GravSim shared definitions: register-file word map, sizing constants and
// the run-controller state type.
package gravsim_pkg;

  localparam int NUM_WORDS  = 114;
  localparam int MAX_BODIES = 10;
  // Timestep as IEEE-754 single (0.01)
  localparam logic [31:0] DT = 32'h3C23_D70A;

  localparam int OFFSET_G      = 0;
  localparam int OFFSET_NUM    = 1;
  localparam int OFFSET_START  = 2;
  localparam int OFFSET_DONE   = 3;
  localparam int OFFSET_MASS   = 4;
  localparam int OFFSET_RADIUS = 14;
  localparam int OFFSET_POS_X  = 24;
  localparam int OFFSET_POS_Y  = 34;
  localparam int OFFSET_POS_Z  = 44;
  localparam int OFFSET_VEL_X  = 54;
  localparam int OFFSET_VEL_Y  = 64;
  localparam int OFFSET_VEL_Z  = 74;
  localparam int OFFSET_ACC_X  = 84;
  localparam int OFFSET_ACC_Y  = 94;
  localparam int OFFSET_ACC_Z  = 104;
  localparam int ACC_END       = OFFSET_ACC_Z + MAX_BODIES;

  localparam int NUM_FSM_PORTS = 6;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_RUN  = 2'd1,
    RS_FIN  = 2'd2
  } run_state_t;

  function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  be);
    byteMerge = oldVal;
    for (int b = 0; b < 4; b++)
      if (be[b]) byteMerge[8*b +: 8] = newVal[8*b +: 8];
  endfunction

endpackage

// File: rtl/gravsim_datafile_if.sv
// Avalon-MM slave bus between the NIOS II and the GravSim register file.
interface gravsim_datafile_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [6:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/gravsim_run_ctrl.sv
// Timestep run controller: IDLE/RUN/FIN sequencing, FSM start request,
// completion interrupt and software write lock.
module gravsim_run_ctrl
  import gravsim_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic startNext,   // word 2 bit 0 as it will be after this edge
  input  logic FSM_DONE,
  output logic FSM_START,
  output logic IRQ,
  output logic doneFlag,
  output logic swLock
);

  run_state_t state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RS_IDLE;
      FSM_START <= 1'b0;
      IRQ       <= 1'b0;
      doneFlag  <= 1'b0;
      swLock    <= 1'b0;
    end else begin
      case (state)
        RS_IDLE: if (startNext) begin
          state     <= RS_RUN;
          FSM_START <= 1'b1;
          swLock    <= 1'b1;
        end
        // An abort (start cleared mid-run) still waits for the FSM to finish
        RS_RUN: if (FSM_DONE) begin
          state    <= RS_FIN;
          IRQ      <= 1'b1;
          doneFlag <= 1'b1;
        end
        RS_FIN: if (!startNext) begin
          state     <= RS_IDLE;
          FSM_START <= 1'b0;
          IRQ       <= 1'b0;
          doneFlag  <= 1'b0;
          swLock    <= 1'b0;
        end
        default: begin
          state     <= RS_IDLE;
          FSM_START <= 1'b0;
          IRQ       <= 1'b0;
          doneFlag  <= 1'b0;
          swLock    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gravsim_datafile.sv
// GravSim working memory: register file with FSM multi-port write-back,
// Avalon-MM software access and the run controller.
module gravsim_datafile
  import gravsim_pkg::*;
#(
  parameter int NUM_WORDS  = gravsim_pkg::NUM_WORDS,
  parameter int MAX_BODIES = gravsim_pkg::MAX_BODIES
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  gravsim_datafile_if.slave           avl,
  output logic                        IRQ,
  output logic                        FSM_START,
  input  logic                        FSM_DONE,
  input  logic [1:0]                  FSM_we,
  input  logic [31:0]                 ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
  input  logic [31:0]                 DATA1, DATA2, DATA3, DATA4, DATA5, DATA6,
  input  logic                        clear_accs,
  output logic [NUM_WORDS-1:0][31:0]  datafile
);

  localparam int AW = $clog2(NUM_WORDS);

  logic [NUM_WORDS-1:0][31:0]     mem, memNxt;
  logic [NUM_FSM_PORTS-1:0][31:0] fAddr, fData;
  logic [NUM_FSM_PORTS-1:0]       fEn;
  logic                           swLock, doneFlag;
  logic                           avlWr, avlRd, avlHit;
  logic [AW-1:0]                  avlIdx;
  logic [31:0]                    avlOld, avlMerged, avlVal;

  assign fAddr = {ADDR6, ADDR5, ADDR4, ADDR3, ADDR2, ADDR1};
  assign fData = {DATA6, DATA5, DATA4, DATA3, DATA2, DATA1};
  assign fEn   = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};

  assign avlWr  = avl.AVL_CS & avl.AVL_WRITE;
  assign avlRd  = avl.AVL_CS & avl.AVL_READ;
  assign avlHit = int'(avl.AVL_ADDR) < NUM_WORDS;
  assign avlIdx = avl.AVL_ADDR[AW-1:0];

  always_comb begin
    avlOld    = avlHit ? mem[avlIdx] : '0;
    avlMerged = byteMerge(avlOld, avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
    avlVal    = avlMerged;
    if (int'(avl.AVL_ADDR) == OFFSET_NUM && avlMerged > 32'(MAX_BODIES))
      avlVal = 32'(MAX_BODIES);
  end

  // Lowest priority first so later assignments win: Avalon, ports 1..6, clear
  always_comb begin
    memNxt = mem;
    if (avlWr && avlHit && int'(avl.AVL_ADDR) != OFFSET_DONE &&
        (!swLock || int'(avl.AVL_ADDR) == OFFSET_START))
      memNxt[avlIdx] = avlVal;
    for (int p = 0; p < NUM_FSM_PORTS; p++)
      if (fEn[p] && fAddr[p] >= 32'(OFFSET_MASS) && fAddr[p] < 32'(NUM_WORDS))
        memNxt[fAddr[p][AW-1:0]] = fData[p];
    if (clear_accs)
      for (int w = OFFSET_ACC_X; w < ACC_END && w < NUM_WORDS; w++)
        memNxt[w] = '0;
    // DONE is owned by the controller, never stored here
    memNxt[OFFSET_DONE] = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem              <= '0;
      avl.AVL_READDATA <= '0;
    end else begin
      mem <= memNxt;
      if (avlRd)
        avl.AVL_READDATA <= avlHit ? datafile[avlIdx] : '0;
    end
  end

  always_comb begin
    datafile              = mem;
    datafile[OFFSET_DONE] = {31'b0, doneFlag};
  end

  gravsim_run_ctrl u_run_ctrl (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .startNext (memNxt[OFFSET_START][0]),
    .FSM_DONE  (FSM_DONE),
    .FSM_START (FSM_START),
    .IRQ       (IRQ),
    .doneFlag  (doneFlag),
    .swLock    (swLock)
  );

endmodule

// File: doc/gravsim_datafile.md
# gravsim_datafile

Holds the GravSim working memory: a 114-word × 32-bit register file presented in parallel to the timestep FSM as `datafile`. It also absorbs the FSM's multi-port write-back (`FSM_we`/`ADDR1-6`/`DATA1-6`, `clear_accs`) and exposes all words to the NIOS II over an Avalon-MM slave. A small run controller generates `FSM_START`, locks software out during a timestep and raises an interrupt on completion.

## Interface
- `NUM_WORDS`, 114: register file depth (word map in `gravsim_pkg`).
- `MAX_BODIES`, 10: upper clamp for word 1 (NUM).
- `CLK` in 1: system clock; all state on rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `AVL_CS` in 1: Avalon chip select.
- `AVL_READ` in 1: read strobe, qualified by `AVL_CS`.
- `AVL_WRITE` in 1: write strobe, qualified by `AVL_CS`.
- `AVL_ADDR` in 7: word address.
- `AVL_BYTE_EN` in 4: byte enables for writes.
- `AVL_WRITEDATA` in 32: write data.
- `AVL_READDATA` out 32: read data.
- `IRQ` out 1: level interrupt; timestep finished.
- `FSM_START` out 1: run request to FSM.
- `FSM_DONE` in 1: FSM completion.
- `FSM_we` in 2: bit0 enables ports 1-3, bit1 enables ports 4-6.
- `ADDR1`..`ADDR6` in 32 each: write word indices.
- `DATA1`..`DATA6` in 32 each: write data.
- `clear_accs` in 1: zero all acceleration words.
- `datafile` out 32×`NUM_WORDS`: parallel view of every word.

## Operation
- Word map: 0 G, 1 NUM, 2 START, 3 DONE, 4-13 mass, 14-23 radius, 24-33/34-43/44-53 pos x/y/z, 54-83 vel x/y/z, 84-113 acc x/y/z.
- Controller states:
  - IDLE → RUN when word2[0]=1.
  - RUN → FIN when `FSM_DONE`=1.
  - FIN → IDLE when word2[0]=0.
- Outputs by state:
  - `FSM_START` = 1 in RUN and FIN.
  - Word 3 = 1 in FIN only, 0 otherwise; software read-only.
  - `IRQ` = 1 in FIN.
- Software access:
  - Word 2 is writable in every state.
  - Other words are writable only in IDLE. In RUN/FIN such writes are silently dropped, with no bus stall.
  - Writes to word 3 are always ignored.
  - Byte enables are honoured per byte.
  - Writes to word 1 saturate: stored value = min(written value, `MAX_BODIES`), applied after byte merge.
  - `AVL_ADDR` ≥ `NUM_WORDS`: write ignored, read returns 0.
- FSM writes:
  - Accepted in any state.
  - Per enabled port, the word at `ADDRn` takes `DATAn`.
  - Index ≥ `NUM_WORDS` is ignored.
  - Indices 0-3 are ignored; FSM cannot alter G/NUM/START/DONE.
- Same-cycle priority, highest first:
  1. `clear_accs`, on words 84-113.
  2. FSM port 6 down to port 1 (higher port number wins on duplicate index).
  3. Avalon write.

## Timing
- Reset (async assert, sync release): all words 0, state IDLE, `FSM_START`=0, `IRQ`=0, `AVL_READDATA`=0.
- Writes (Avalon, FSM, clear): visible on `datafile` and readback the cycle after the sampling edge.
- Read latency 1: `AVL_READDATA` is registered on the edge where `AVL_CS & AVL_READ`. It holds otherwise.
- Read and write of the same word in the same cycle returns the old value.
- Controller reaction:
  - `FSM_START` rises one cycle after the word-2 write is sampled.
  - Word 3 and `IRQ` rise one cycle after `FSM_DONE` is sampled high.
  - `FSM_START` falls one cycle after word 2 is cleared.
- Software clears word 2 in RUN (abort): state stays RUN until `FSM_DONE`, then passes through FIN for exactly one cycle and returns to IDLE.
- `RESET_N` low mid-timestep: everything returns to reset values immediately; no write completes.

## Structure
- `gravsim_pkg` holds:
  - word offsets (`OFFSET_G`, `OFFSET_NUM`, `OFFSET_START`, `OFFSET_DONE`, `OFFSET_MASS` … `OFFSET_ACC_Z`);
  - `NUM_WORDS`, `MAX_BODIES`, `DT`;
  - the controller state enum `run_state_t`.
- One sub-module: `gravsim_run_ctrl` (IDLE/RUN/FIN, `FSM_START`, `IRQ`, write lock). Storage and write resolution stay in `gravsim_datafile`.

## Test plan
- Reset release, then read words 0-113 → all 0; `FSM_START`=0, `IRQ`=0.
- Avalon write 0x0000001F to word 1 → readback 10. Byte-enable 4'b0010 write 0xAB00 to word 0 → only bits 15:8 change.
- Write word2=1 → `FSM_START` high next cycle. Write 0x3F800000 to word 24 while RUN → word 24 unchanged. Assert `FSM_DONE` → word3=1 and `IRQ`=1 next cycle. Write word2=0 → IDLE, `FSM_START`=0.
- `FSM_we`=3 with `ADDR2`=`ADDR5`=95, `DATA2`=0x1, `DATA5`=0x2 → word 95=0x2. Same cycle with `clear_accs` → word 95=0.
- FSM write to `ADDR1`=1 or `ADDR1`=200 → no word changes. Avalon read of address 120 → 0.
- Drop `RESET_N` while RUN with `FSM_we` active → all words 0, IDLE, no write lands.
